// File: rtl/vga_timing_gen.sv
// Parametrised video sync generator: pixel/line counters with registered decodes,
// line/frame strobes and a pausable, loadable frame counter.
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_BOTTOM  = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_TOP     = 33,
    parameter bit          H_POL     = 1'b0,
    parameter bit          V_POL     = 1'b0,
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned FRAME_W   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               frame_pause,
    input  logic               frame_load,
    input  logic [FRAME_W-1:0] frame_din,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               vblank,
    output logic [COORD_W-1:0] hpos,
    output logic [COORD_W-1:0] vpos,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame
);

    localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_DISPLAY + V_BOTTOM;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int unsigned MAX_TOTAL    = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    if (COORD_W < $clog2(MAX_TOTAL)) begin : g_coord_w_check
        $error("vga_timing_gen: COORD_W too narrow for H_TOTAL/V_TOTAL");
    end

    logic [COORD_W-1:0] hpos_q, hpos_d;
    logic [COORD_W-1:0] vpos_q, vpos_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               display_on_q, display_on_d;
    logic               vblank_q, vblank_d;
    logic               line_start_q, frame_start_q;
    logic               h_wrap, f_wrap;
    logic [31:0]        hpos_ext, vpos_ext;

    assign h_wrap = ce && (hpos_q == H_LAST);
    assign f_wrap = h_wrap && (vpos_q == V_LAST);

    always_comb begin
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        if (ce) begin
            if (h_wrap) begin
                hpos_d = '0;
                vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + COORD_W'(1);
            end else begin
                hpos_d = hpos_q + COORD_W'(1);
            end
        end
    end

    // Decodes look at the next-state counters so they line up with hpos/vpos.
    assign hpos_ext = 32'(hpos_d);
    assign vpos_ext = 32'(vpos_d);

    always_comb begin
        hsync_d      = ((hpos_ext >= H_SYNC_START) && (hpos_ext < H_SYNC_END)) ? H_POL : ~H_POL;
        vsync_d      = ((vpos_ext >= V_SYNC_START) && (vpos_ext < V_SYNC_END)) ? V_POL : ~V_POL;
        display_on_d = (hpos_ext < H_DISPLAY) && (vpos_ext < V_DISPLAY);
        vblank_d     = (vpos_ext >= V_DISPLAY);
    end

    // Load wins over a coincident frame-wrap increment.
    always_comb begin
        frame_d = frame_q;
        if (frame_load) begin
            frame_d = frame_din;
        end else if (f_wrap && !frame_pause) begin
            frame_d = frame_q + FRAME_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q        <= '0;
            vpos_q        <= '0;
            frame_q       <= '0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            display_on_q  <= 1'b0;
            vblank_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            frame_q       <= frame_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            vblank_q      <= vblank_d;
            line_start_q  <= h_wrap;
            frame_start_q <= f_wrap;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame       = frame_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign vblank      = vblank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 14x7 configuration: per-cycle scoreboard of expected
// outputs plus directed checks at hand-computed points.
module tb_vga_timing_gen;

    logic       clk;
    logic       reset;
    logic       ce;
    logic       frame_pause;
    logic       frame_load;
    logic [3:0] frame_din;
    logic       hsync, vsync, display_on, vblank, line_start, frame_start;
    logic [3:0] hpos, vpos, frame;

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(1),
        .H_POL(1'b0), .V_POL(1'b0), .COORD_W(4), .FRAME_W(4)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .frame_pause(frame_pause),
        .frame_load(frame_load), .frame_din(frame_din),
        .hsync(hsync), .vsync(vsync), .display_on(display_on), .vblank(vblank),
        .hpos(hpos), .vpos(vpos), .line_start(line_start), .frame_start(frame_start),
        .frame(frame)
    );

    typedef struct packed {
        logic [3:0] hpos;
        logic [3:0] vpos;
        logic [3:0] frame;
        logic       hs;
        logic       vs;
        logic       de;
        logic       vb;
        logic       ls;
        logic       fs;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;

    int         m_h;
    int         m_v;
    logic [3:0] m_f;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected entry per clock, compared just after the edge.
    obs_t mon_e, mon_a;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = '{hpos, vpos, frame, hsync, vsync, display_on, vblank, line_start, frame_start};
            cyc_n++;
            total++;
            if (mon_a !== mon_e) begin
                bad++;
                $display("FAIL cycle_%0d got h=%0d v=%0d f=%0d hs=%b vs=%b de=%b vb=%b ls=%b fs=%b want h=%0d v=%0d f=%0d hs=%b vs=%b de=%b vb=%b ls=%b fs=%b",
                         cyc_n, mon_a.hpos, mon_a.vpos, mon_a.frame, mon_a.hs, mon_a.vs, mon_a.de,
                         mon_a.vb, mon_a.ls, mon_a.fs, mon_e.hpos, mon_e.vpos, mon_e.frame,
                         mon_e.hs, mon_e.vs, mon_e.de, mon_e.vb, mon_e.ls, mon_e.fs);
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus, push the expected post-edge outputs, wait to next negedge.
    task automatic tick(input logic r, input logic c, input logic p, input logic l,
                        input logic [3:0] d);
        obs_t e;
        logic wrap_h, wrap_f;
        reset = r; ce = c; frame_pause = p; frame_load = l; frame_din = d;
        if (r) begin
            m_h = 0; m_v = 0; m_f = 4'd0;
            e = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        end else begin
            wrap_h = c && (m_h == 13);
            wrap_f = wrap_h && (m_v == 6);
            if (c) begin
                if (wrap_h) begin
                    m_h = 0;
                    m_v = (m_v == 6) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
            end
            if (l) m_f = d;
            else if (wrap_f && !p) m_f = m_f + 4'd1;
            e.hpos  = 4'(m_h);
            e.vpos  = 4'(m_v);
            e.frame = m_f;
            e.hs    = !(m_h == 10 || m_h == 11);
            e.vs    = !(m_v == 5);
            e.de    = (m_h < 8) && (m_v < 4);
            e.vb    = (m_v >= 4);
            e.ls    = wrap_h;
            e.fs    = wrap_f;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    int hs_low, hs_badpos, vs_low, vs_badpos, ls_cnt, fs_cnt;

    initial begin
        reset = 1'b1; ce = 1'b0; frame_pause = 1'b0; frame_load = 1'b0; frame_din = 4'd0;
        m_h = 0; m_v = 0; m_f = 4'd0;
        @(negedge clk);

        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("reset_hpos", int'(hpos), 0);
        chk("reset_hsync", int'(hsync), 1);

        // One full frame: first line wrap, sync placement, frame wrap.
        hs_low = 0; hs_badpos = 0; vs_low = 0; vs_badpos = 0; ls_cnt = 0; fs_cnt = 0;
        for (int k = 1; k <= 98; k++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            if (!hsync) begin
                hs_low++;
                if (hpos != 4'd10 && hpos != 4'd11) hs_badpos++;
            end
            if (!vsync) begin
                vs_low++;
                if (vpos != 4'd5) vs_badpos++;
            end
            if (line_start) ls_cnt++;
            if (frame_start) fs_cnt++;
            if (k == 14) begin
                chk("t1_line_hpos", int'(hpos), 0);
                chk("t1_line_vpos", int'(vpos), 1);
                chk("t1_line_start", int'(line_start), 1);
            end
        end
        chk("t2_fs", int'(frame_start), 1);
        chk("t2_fs_hpos", int'(hpos), 0);
        chk("t2_fs_vpos", int'(vpos), 0);
        chk("t2_frame", int'(frame), 1);
        chk("t2_hs_low", hs_low, 14);
        chk("t2_hs_badpos", hs_badpos, 0);
        chk("t2_vs_low", vs_low, 14);
        chk("t2_vs_badpos", vs_badpos, 0);
        chk("t2_ls_cnt", ls_cnt, 7);
        chk("t2_fs_cnt", fs_cnt, 1);

        // ce toggling: 20 advances from (0,0) land on (6,1).
        for (int k = 0; k < 40; k++) tick(1'b0, (k % 2) == 0, 1'b0, 1'b0, 4'd0);
        chk("t3_hpos", int'(hpos), 6);
        chk("t3_vpos", int'(vpos), 1);

        // Load 0xF, then run to the frame wrap: 0xF + 1 wraps to 0.
        tick(1'b0, 1'b1, 1'b0, 1'b1, 4'hF);
        chk("t4_load", int'(frame), 15);
        repeat (77) tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("t4_wrap_fs", int'(frame_start), 1);
        chk("t4_wrap_frame", int'(frame), 0);
        repeat (97) tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
        chk("t4_load_at_wrap_fs", int'(frame_start), 1);
        chk("t4_load_at_wrap", int'(frame), 5);

        // Paused frame counter across two frames.
        fs_cnt = 0;
        for (int k = 0; k < 196; k++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
            if (frame_start) fs_cnt++;
        end
        chk("t5_fs_cnt", fs_cnt, 2);
        chk("t5_frame", int'(frame), 5);

        // Reset mid-frame overriding ce/load/pause.
        repeat (48) tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("t6_pre_hpos", int'(hpos), 6);
        chk("t6_pre_vpos", int'(vpos), 3);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
        chk("t6_rst_hpos", int'(hpos), 0);
        chk("t6_rst_vpos", int'(vpos), 0);
        chk("t6_rst_frame", int'(frame), 0);
        chk("t6_rst_de", int'(display_on), 0);
        chk("t6_rst_vsync", int'(vsync), 1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("t6_exit_de", int'(display_on), 1);
        chk("t6_exit_ls", int'(line_start), 0);
        chk("t6_exit_hpos", int'(hpos), 0);
        repeat (14) tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("t6_restart_ls", int'(line_start), 1);
        chk("t6_restart_vpos", int'(vpos), 1);

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
